// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai31_bist.sv
// BIST sequencer for one oai31 cell: drives 16 Gray-ordered input vectors, samples ZN after a settle
// interval, and reports pass/fail, a mismatch count and the first failing vector {B,A3,A2,A1}.
module gf180mcu_fd_sc_mcu9t5v0__oai31_bist #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       START,
  input  logic       ABORT,
  input  logic       ZN_DUT,
  output logic       A1_DRV,
  output logic       A2_DRV,
  output logic       A3_DRV,
  output logic       B_DRV,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [4:0] ERR_CNT,
  output logic [3:0] FAIL_VEC,
  output logic       FAIL_VALID
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC);

  state_t     state_q;
  logic [3:0] idx_q;
  logic [3:0] cyc_q;
  logic [3:0] drv_q;
  logic [3:0] fail_vec_q;
  logic [4:0] err_cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic       fail_valid_q;

  logic       exp_zn;
  logic       mismatch;
  logic [3:0] idx_nxt;
  logic [3:0] vec_nxt;
  logic [4:0] err_cnt_d;

  always_comb begin
    exp_zn    = ~((drv_q[0] | drv_q[1] | drv_q[2]) & drv_q[3]);
    // Case inequality so an X/Z from the cell under test is flagged rather than masked.
    mismatch  = (ZN_DUT !== exp_zn);
    idx_nxt   = idx_q + 4'd1;
    vec_nxt   = idx_nxt ^ (idx_nxt >> 1);
    err_cnt_d = err_cnt_q + {4'd0, mismatch};
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      cyc_q        <= 4'd0;
      drv_q        <= 4'd0;
      fail_vec_q   <= 4'd0;
      err_cnt_q    <= 5'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
    end else if (ABORT) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      cyc_q        <= 4'd0;
      drv_q        <= 4'd0;
      fail_vec_q   <= 4'd0;
      err_cnt_q    <= 5'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FIN: begin
          if (START) begin
            state_q      <= S_RUN;
            idx_q        <= 4'd0;
            cyc_q        <= 4'd0;
            drv_q        <= 4'd0;
            fail_vec_q   <= 4'd0;
            err_cnt_q    <= 5'd0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (cyc_q != SETTLE_LAST) begin
            cyc_q <= cyc_q + 4'd1;
          end else begin
            cyc_q     <= 4'd0;
            err_cnt_q <= err_cnt_d;
            if (mismatch && !fail_valid_q) begin
              fail_vec_q   <= drv_q;
              fail_valid_q <= 1'b1;
            end
            if (idx_q == 4'd15) begin
              state_q <= S_FIN;
              drv_q   <= 4'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == 5'd0);
            end else begin
              idx_q <= idx_nxt;
              drv_q <= vec_nxt;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign A1_DRV     = drv_q[0];
  assign A2_DRV     = drv_q[1];
  assign A3_DRV     = drv_q[2];
  assign B_DRV      = drv_q[3];
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign ERR_CNT    = err_cnt_q;
  assign FAIL_VEC   = fail_vec_q;
  assign FAIL_VALID = fail_valid_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__oai31_bist.sv
// Scoreboard bench for the oai31 BIST sequencer: a fault-injecting cell model answers the drives,
// expected sweep results are queued at START and checked by a monitor when DONE rises.
module tb_gf180mcu_fd_sc_mcu9t5v0__oai31_bist;

  typedef struct {
    logic [4:0] err;
    logic [3:0] fvec;
    logic       fvalid;
    logic       pass;
  } res_t;

  logic       CLK;
  logic       RN;
  logic       START;
  logic       ABORT;
  logic       ZN_DUT;
  logic       A1_DRV, A2_DRV, A3_DRV, B_DRV;
  logic       BUSY, DONE, PASS, FAIL_VALID;
  logic [4:0] ERR_CNT;
  logic [3:0] FAIL_VEC;

  int          n_cmp;
  int          n_err;
  int          mode;       // 0 good cell, 1 stuck-0, 2 stuck-1, 3 good cell with per-vector flips
  logic [15:0] flip_mask;
  res_t        exp_q[$];

  gf180mcu_fd_sc_mcu9t5v0__oai31_bist #(.SETTLE_CYC(2)) dut (
    .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT), .ZN_DUT(ZN_DUT),
    .A1_DRV(A1_DRV), .A2_DRV(A2_DRV), .A3_DRV(A3_DRV), .B_DRV(B_DRV),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT),
    .FAIL_VEC(FAIL_VEC), .FAIL_VALID(FAIL_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    logic good;
    good = ~((A1_DRV | A2_DRV | A3_DRV) & B_DRV);
    case (mode)
      1:       ZN_DUT = 1'b0;
      2:       ZN_DUT = 1'b1;
      3:       ZN_DUT = good ^ flip_mask[{B_DRV, A3_DRV, A2_DRV, A1_DRV}];
      default: ZN_DUT = good;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] gray(input int i);
    logic [3:0] v;
    v = 4'(i);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [3:0] drv_now();
    return {B_DRV, A3_DRV, A2_DRV, A1_DRV};
  endfunction

  // Reference: walk the 16 vectors, apply the fault mode, count disagreements with the oai31 truth.
  function automatic res_t model(input int m, input logic [15:0] msk);
    res_t r;
    logic [3:0] v;
    logic good, zn;
    r = '{err: 5'd0, fvec: 4'd0, fvalid: 1'b0, pass: 1'b0};
    for (int i = 0; i < 16; i++) begin
      v    = gray(i);
      good = !((v[0] || v[1] || v[2]) && v[3]);
      case (m)
        1:       zn = 1'b0;
        2:       zn = 1'b1;
        3:       zn = good ^ msk[v];
        default: zn = good;
      endcase
      if (zn != good) begin
        r.err = r.err + 5'd1;
        if (!r.fvalid) begin
          r.fvec   = v;
          r.fvalid = 1'b1;
        end
      end
    end
    r.pass = (r.err == 5'd0);
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_drv"}, drv_now(), 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_pass"}, PASS, 0);
    chk({tag, "_err"}, ERR_CNT, 0);
    chk({tag, "_fvec"}, FAIL_VEC, 0);
    chk({tag, "_fvalid"}, FAIL_VALID, 0);
  endtask

  task automatic run_sweep(input int m, input logic [15:0] msk);
    int n;
    mode      = m;
    flip_mask = msk;
    START     = 1'b1;
    exp_q.push_back(model(m, msk));
    tick();
    START = 1'b0;
    n = 0;
    while (!DONE && n < 200) begin
      tick();
      n++;
    end
    chk("done_edge", n, 48);
    repeat ($urandom_range(1, 5)) tick();
  endtask

  // Monitor: vector sequence, one-bit steps, BUSY length, and end-of-sweep results against the queue.
  initial begin
    logic       prev_busy, prev_done;
    logic [3:0] prev_drv;
    int         step, busy_cyc;
    res_t       e;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    prev_drv  = 4'd0;
    step      = 0;
    busy_cyc  = 0;
    forever begin
      @(negedge CLK);
      if (BUSY && !prev_busy) begin
        step     = 0;
        busy_cyc = 0;
        chk("first_vec", drv_now(), 0);
      end else if (BUSY && drv_now() != prev_drv) begin
        step++;
        chk("drv_seq", drv_now(), gray(step));
        chk("one_bit_step", $countones(drv_now() ^ prev_drv), 1);
      end
      if (BUSY) busy_cyc++;
      if (DONE && !prev_done) begin
        chk("fin_drv_zero", drv_now(), 0);
        chk("busy_len", busy_cyc, 48);
        chk("step_count", step, 15);
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("err_cnt", ERR_CNT, e.err);
          chk("fail_vec", FAIL_VEC, e.fvec);
          chk("fail_valid", FAIL_VALID, e.fvalid);
          chk("pass", PASS, e.pass);
        end
      end
      prev_busy = BUSY;
      prev_done = DONE;
      prev_drv  = drv_now();
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_cmp     = 0;
    n_err     = 0;
    mode      = 0;
    flip_mask = 16'h0;
    RN        = 1'b0;
    START     = 1'b0;
    ABORT     = 1'b0;
    #12;
    check_cleared("reset");
    @(posedge CLK);
    #1 RN = 1'b1;

    run_sweep(0, 16'h0);
    chk("good_pass", PASS, 1);
    run_sweep(1, 16'h0);
    chk("stuck0_err", ERR_CNT, 9);
    chk("stuck0_fvec", FAIL_VEC, 4'h0);
    run_sweep(2, 16'h0);
    chk("stuck1_err", ERR_CNT, 7);
    chk("stuck1_fvec", FAIL_VEC, 4'hC);
    for (int k = 0; k < 6; k++) run_sweep(3, 16'($urandom));
    run_sweep(3, 16'h8000);
    run_sweep(3, 16'hFFFF);

    // ABORT at edge 20, then START held from edge 25 while BUSY.
    mode  = 0;
    START = 1'b1;
    exp_q.push_back(model(0, 16'h0));
    tick();
    START = 1'b0;
    repeat (19) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    void'(exp_q.pop_back());
    check_cleared("abort");
    repeat (4) tick();
    START = 1'b1;
    exp_q.push_back(model(0, 16'h0));
    n = 0;
    do begin
      tick();
      n++;
    end while (BUSY && n < 200);
    START = 1'b0;
    chk("rearm_done_edge", n, 49);
    chk("rearm_done", DONE, 1);
    repeat (3) tick();

    // Asynchronous reset in the middle of vector 5.
    mode  = 3;
    flip_mask = 16'h0F0F;
    START = 1'b1;
    exp_q.push_back(model(3, 16'h0F0F));
    tick();
    START = 1'b0;
    n = 0;
    while (drv_now() != gray(5) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_vec5", drv_now(), gray(5));
    #2 RN = 1'b0;
    #1;
    check_cleared("async_rst");
    void'(exp_q.pop_back());
    #1 RN = 1'b1;
    tick();
    run_sweep(0, 16'h0);
    chk("post_rst_pass", PASS, 1);

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__oai31_bist.md
# gf180mcu_fd_sc_mcu9t5v0__oai31_bist

Built-in self-test sequencer for one oai31 cell instance, where ZN = ~((A1|A2|A3)&B). On START it drives all 16 input combinations to the cell in Gray-code order, so each step toggles exactly one input and exercises one timing arc. After each step it waits a settle interval, samples the cell's ZN and compares it with the expected value. It sits beside the cell under test in library silicon-validation and characterization wrappers, and reports pass/fail, an error count and the first failing vector.

## Interface
Parameters:
- SETTLE_CYC, 2, number of cycles each vector is held before ZN is sampled; legal range 1..15.

Ports:
- CLK  input  1  clock; rising-edge active.
- RN  input  1  reset, asynchronous, active-low.
- START  input  1  single-cycle sweep request.
- ABORT  input  1  single-cycle sweep cancel.
- ZN_DUT  input  1  ZN output of the cell under test.
- A1_DRV, A2_DRV, A3_DRV, B_DRV  output  1 each  registered drives to the cell inputs.
- BUSY  output  1  high while a sweep is running.
- DONE  output  1  high once a sweep completes; held until the next START, ABORT or reset.
- PASS  output  1  meaningful only when DONE=1; 1 means ERR_CNT==0.
- ERR_CNT  output  5  number of mismatches in the last sweep, 0..16.
- FAIL_VEC  output  4  first failing vector, packed {B,A3,A2,A1}.
- FAIL_VALID  output  1  high once FAIL_VEC has been captured.

## Operation
- States:
  - IDLE: waiting for START.
  - RUN: applying vectors and sampling ZN.
  - FIN: sweep complete, results held.
- Transitions:
  - IDLE→RUN on START.
  - RUN→FIN after the 16th sample.
  - FIN→RUN on START.
  - RUN or FIN→IDLE on ABORT.
- ABORT has priority over START when both are high in the same cycle.
- START is ignored while in RUN.
- Vector index i runs 0..15. The applied vector is i^(i>>1), mapped to {B,A3,A2,A1}.
  - Sequence: 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8.
- Expected value: exp = ~((A1|A2|A3)&B) of the applied vector.
- Mismatch test: ZN_DUT !== exp. An X or Z on ZN_DUT therefore counts as a mismatch.
- On a mismatch:
  - ERR_CNT increments. Its maximum is 16, so it needs no saturation logic.
  - If this is the first mismatch of the sweep, FAIL_VEC takes the applied vector and FAIL_VALID is set.
- Entering RUN clears ERR_CNT, FAIL_VEC and FAIL_VALID, and deasserts DONE and PASS.
- In FIN the drives return to 0000. ERR_CNT, FAIL_VEC, FAIL_VALID and PASS are held.
- ABORT clears all status and drives 0000.

## Timing
- Reset (RN low, asynchronous) forces:
  - all drive outputs 0;
  - BUSY, DONE, PASS and FAIL_VALID 0;
  - ERR_CNT 0 and FAIL_VEC 0;
  - state IDLE.
- Reset release is synchronous to CLK. The first START is accepted on the first rising edge with RN high.
- Call the edge that samples START edge 0.
  - BUSY rises and vector 0 is driven after edge 0.
  - Each vector is held for SETTLE_CYC+1 cycles.
  - ZN_DUT is sampled on the last edge of each hold interval.
  - The next vector is driven after that same edge.
- Sample k (k=0..15) is taken at edge (k+1)(SETTLE_CYC+1).
- After the final sample edge, 16(SETTLE_CYC+1):
  - BUSY falls, DONE rises and PASS is valid;
  - ERR_CNT already includes that final sample.
- Total sweep with SETTLE_CYC=2: DONE is high after edge 48.
- ABORT sampled at any edge: the block is in IDLE with all outputs at reset values after that edge.
- RN asserted mid-sweep: immediate asynchronous return to reset values; no partial results are kept.
- Drive outputs change only on CLK edges. Exactly one drive bit changes per vector step within a sweep.

## Test plan
- Correct DUT model, SETTLE_CYC=2, START pulse → BUSY for 48 cycles, then DONE=1, PASS=1, ERR_CNT=0, FAIL_VALID=0.
- ZN_DUT stuck at 0 → DONE with PASS=0, ERR_CNT=9, FAIL_VEC=4'h0, FAIL_VALID=1.
- ZN_DUT stuck at 1 → ERR_CNT=7, FAIL_VEC=4'hC, captured at sample 8.
- Drive monitor across a full sweep → the 16-vector sequence above, exactly one bit changing per step.
- ABORT at edge 20, then START at edge 25 and on every following edge while BUSY:
  - IDLE with all status 0 after edge 20;
  - the new sweep starts from vector 0;
  - the repeated STARTs while BUSY have no effect;
  - DONE is high after edge 25+48.
- RN pulsed low mid-cycle during sweep vector 5 → all outputs 0 immediately, without waiting for CLK; the next START runs a clean full sweep.
